// File: rtl/sponge_pkg.sv
// Shared types and constants for the sponge construction controller.
// Modes, FSM states and the rate in bytes for each mode.
package sponge_pkg;

    typedef enum logic [1:0] {
        ModeShake128 = 2'd0,
        ModeShake256 = 2'd1,
        ModeSha3_256 = 2'd2,
        ModeSha3_512 = 2'd3
    } mode_t;

    typedef enum logic [2:0] {
        StIdle,
        StWaitAbsorb,
        StPermute,
        StDump,
        StSqueeze
    } state_t;

    localparam int unsigned RateShake128 = 168;
    localparam int unsigned RateShake256 = 136;
    localparam int unsigned RateSha3_256 = 136;
    localparam int unsigned RateSha3_512 = 72;

    localparam int unsigned NumRoundsDefault = 24;

    function automatic int unsigned rate_bytes(input mode_t mode);
        int unsigned rate;
        unique case (mode)
            ModeShake128: rate = RateShake128;
            ModeShake256: rate = RateShake256;
            ModeSha3_256: rate = RateSha3_256;
            ModeSha3_512: rate = RateSha3_512;
            default:      rate = RateShake128;
        endcase
        return rate;
    endfunction

    // Only the SHAKE modes may emit more than one output block.
    function automatic logic is_xof(input mode_t mode);
        return (mode == ModeShake128) || (mode == ModeShake256);
    endfunction

endpackage

// File: rtl/sponge_ctrl_if.sv
// Handshake and datapath-control signals between the sponge controller and its
// environment; the controller takes the slave side.
interface sponge_ctrl_if #(
    parameter int unsigned CNT_W = 16,
    parameter int unsigned IDX_W = 5
);
    logic             start_i;
    logic [1:0]       mode_i;
    logic [CNT_W-1:0] out_blocks_i;
    logic             in_valid_i;
    logic             in_last_i;
    logic             in_ready_o;
    logic             absorb_en_o;
    logic             state_clr_o;
    logic             round_en_o;
    logic [IDX_W-1:0] round_idx_o;
    logic [1:0]       rate_sel_o;
    logic             out_valid_o;
    logic             out_last_o;
    logic             out_ready_i;
    logic             busy_o;

    modport master (
        output start_i, mode_i, out_blocks_i, in_valid_i, in_last_i, out_ready_i,
        input  in_ready_o, absorb_en_o, state_clr_o, round_en_o, round_idx_o, rate_sel_o,
               out_valid_o, out_last_o, busy_o
    );

    modport slave (
        input  start_i, mode_i, out_blocks_i, in_valid_i, in_last_i, out_ready_i,
        output in_ready_o, absorb_en_o, state_clr_o, round_en_o, round_idx_o, rate_sel_o,
               out_valid_o, out_last_o, busy_o
    );
endinterface

// File: rtl/sponge_round_ctr.sv
// Permutation round counter: steps by ROUNDS_PER_CYCLE and wraps to 0 after the
// final step, flagging that final step.
module sponge_round_ctr #(
    parameter int unsigned NUM_ROUNDS       = 24,
    parameter int unsigned ROUNDS_PER_CYCLE = 1,
    parameter int unsigned IDX_W            = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [IDX_W-1:0] idx,
    output logic             last
);
    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_ROUNDS - ROUNDS_PER_CYCLE);
    localparam logic [IDX_W-1:0] Step    = IDX_W'(ROUNDS_PER_CYCLE);

    logic [IDX_W-1:0] idx_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q <= '0;
        end else if (clr) begin
            idx_q <= '0;
        end else if (en) begin
            idx_q <= last ? '0 : idx_q + Step;
        end
    end

    assign idx  = idx_q;
    assign last = (idx_q == LastIdx);

endmodule

// File: rtl/sponge_ctrl.sv
// Sponge construction sequencer: absorbs padded rate blocks, runs the permutation
// and hands out squeezed blocks, driving the state datapath's control strobes.
module sponge_ctrl import sponge_pkg::*; #(
    parameter int unsigned NUM_ROUNDS       = NumRoundsDefault,
    parameter int unsigned ROUNDS_PER_CYCLE = 1,
    parameter int unsigned CNT_W            = 16
) (
    input  logic          clk,
    input  logic          rst,
    sponge_ctrl_if.slave  bus
);
    localparam int unsigned IdxW = (NUM_ROUNDS > 1) ? $clog2(NUM_ROUNDS) : 1;

    if (ROUNDS_PER_CYCLE == 0) begin : g_bad_step
        $error("ROUNDS_PER_CYCLE must be non-zero");
    end else if (NUM_ROUNDS % ROUNDS_PER_CYCLE != 0) begin : g_bad_rounds
        $error("NUM_ROUNDS must be a multiple of ROUNDS_PER_CYCLE");
    end

    state_t           state_q;
    mode_t            mode_q;
    logic [CNT_W-1:0] remaining_q;
    logic             last_q;
    logic             busy_q;
    logic             round_en_q;
    logic             out_valid_q;
    logic             out_last_q;

    logic             start_ok;
    logic             in_ready;
    logic             accept;
    logic             ctr_last;
    logic [IdxW-1:0]  ctr_idx;
    logic [CNT_W-1:0] start_count;

    assign start_ok = (state_q == StIdle) && bus.start_i && !rst;
    assign in_ready = (state_q == StWaitAbsorb) ||
                      ((state_q == StPermute) && ctr_last && !last_q);
    assign accept   = in_ready && bus.in_valid_i;

    // Fixed-output modes and a zero request both produce exactly one block.
    always_comb begin
        start_count = bus.out_blocks_i;
        if (!is_xof(mode_t'(bus.mode_i)) || (bus.out_blocks_i == '0)) begin
            start_count = CNT_W'(1);
        end
    end

    sponge_round_ctr #(
        .NUM_ROUNDS       (NUM_ROUNDS),
        .ROUNDS_PER_CYCLE (ROUNDS_PER_CYCLE),
        .IDX_W            (IdxW)
    ) u_round_ctr (
        .clk  (clk),
        .rst  (rst),
        .clr  (start_ok || accept),
        .en   (round_en_q),
        .idx  (ctr_idx),
        .last (ctr_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            mode_q      <= ModeShake128;
            remaining_q <= '0;
            last_q      <= 1'b0;
            busy_q      <= 1'b0;
            round_en_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.start_i) begin
                        mode_q      <= mode_t'(bus.mode_i);
                        remaining_q <= start_count;
                        last_q      <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= StWaitAbsorb;
                    end
                end
                StWaitAbsorb: begin
                    if (bus.in_valid_i) begin
                        last_q     <= bus.in_last_i;
                        round_en_q <= 1'b1;
                        state_q    <= StPermute;
                    end
                end
                StPermute: begin
                    if (ctr_last) begin
                        if (last_q) begin
                            round_en_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                            out_last_q  <= (remaining_q == CNT_W'(1));
                            state_q     <= StDump;
                        end else if (bus.in_valid_i) begin
                            // Back-to-back block: the counter wraps and rounds keep running.
                            last_q <= bus.in_last_i;
                        end else begin
                            round_en_q <= 1'b0;
                            state_q    <= StWaitAbsorb;
                        end
                    end
                end
                StDump: begin
                    if (bus.out_ready_i) begin
                        remaining_q <= remaining_q - CNT_W'(1);
                        out_valid_q <= 1'b0;
                        out_last_q  <= 1'b0;
                        if (out_last_q) begin
                            busy_q  <= 1'b0;
                            state_q <= StIdle;
                        end else begin
                            round_en_q <= 1'b1;
                            state_q    <= StSqueeze;
                        end
                    end
                end
                StSqueeze: begin
                    if (ctr_last) begin
                        round_en_q  <= 1'b0;
                        out_valid_q <= 1'b1;
                        out_last_q  <= (remaining_q == CNT_W'(1));
                        state_q     <= StDump;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.in_ready_o  = in_ready;
    assign bus.absorb_en_o = accept;
    assign bus.state_clr_o = start_ok;
    assign bus.round_en_o  = round_en_q;
    assign bus.round_idx_o = ctr_idx;
    assign bus.rate_sel_o  = mode_q;
    assign bus.out_valid_o = out_valid_q;
    assign bus.out_last_o  = out_last_q;
    assign bus.busy_o      = busy_q;

endmodule

// File: tb/tb_sponge_ctrl.sv
// Randomized scoreboard bench for sponge_ctrl (R=1), plus a directed run of a
// two-rounds-per-cycle instance.
module tb_sponge_ctrl;
    import sponge_pkg::*;

    localparam int unsigned NR = 24;
    localparam int unsigned CW = 16;
    localparam int unsigned IW = $clog2(NR);

    typedef struct {
        bit last;
        int rounds;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sponge_ctrl_if #(.CNT_W(CW), .IDX_W(IW)) bus ();
    sponge_ctrl_if #(.CNT_W(CW), .IDX_W(IW)) bus2 ();

    sponge_ctrl #(.NUM_ROUNDS(NR), .ROUNDS_PER_CYCLE(1), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    sponge_ctrl #(.NUM_ROUNDS(NR), .ROUNDS_PER_CYCLE(2), .CNT_W(CW)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    int checks = 0;
    int errors = 0;
    exp_t exp_q[$];
    int rounds_cnt = 0;
    int absorb_cnt = 0;
    logic [1:0] job_mode = 2'd0;
    int stall_left = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Consumer: random backpressure, with an optional forced stall in DUMP.
    initial begin
        bus.out_ready_i = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.out_valid_o && stall_left > 0) begin
                bus.out_ready_i = 1'b0;
                stall_left--;
            end else begin
                bus.out_ready_i = ($urandom_range(0, 3) != 0);
            end
        end
    end

    // Monitor: pops the scoreboard on every output transfer, checks invariants.
    initial begin
        bit p_ov, p_ol, p_tk;
        int nact;
        exp_t e;
        p_ov = 0; p_ol = 0; p_tk = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                p_ov = 0; p_tk = 0;
            end else begin
                nact = int'(bus.absorb_en_o) + int'(bus.state_clr_o) + int'(bus.out_valid_o);
                check("strobe_exclusive", int'(nact <= 1), 1);
                if (bus.state_clr_o) begin
                    rounds_cnt = 0;
                    absorb_cnt = 0;
                end
                if (bus.absorb_en_o) absorb_cnt++;
                if (bus.busy_o) check("rate_sel", int'(bus.rate_sel_o), int'(job_mode));
                if (p_ov && !p_tk) begin
                    check("dump_hold_valid", int'(bus.out_valid_o), 1);
                    check("dump_hold_last", int'(bus.out_last_o), int'(p_ol));
                end
                if (bus.out_valid_o) begin
                    check("dump_no_round", int'(bus.round_en_o), 0);
                    if (bus.out_ready_i) begin
                        if (exp_q.size() == 0) begin
                            check("unexpected_output", exp_q.size(), 1);
                        end else begin
                            e = exp_q.pop_front();
                            check("out_last", int'(bus.out_last_o), int'(e.last));
                            check("out_rounds", rounds_cnt, e.rounds);
                        end
                    end
                end
                if (bus.round_en_o) begin
                    check("round_idx", int'(bus.round_idx_o), rounds_cnt % NR);
                    rounds_cnt++;
                end
                p_ov = bus.out_valid_o;
                p_ol = bus.out_last_o;
                p_tk = bus.out_valid_o && bus.out_ready_i;
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, int'(bus.busy_o), 0);
        check({tag, "_round_en"}, int'(bus.round_en_o), 0);
        check({tag, "_out_valid"}, int'(bus.out_valid_o), 0);
        check({tag, "_out_last"}, int'(bus.out_last_o), 0);
        check({tag, "_in_ready"}, int'(bus.in_ready_o), 0);
        check({tag, "_state_clr"}, int'(bus.state_clr_o), 0);
        check({tag, "_absorb"}, int'(bus.absorb_en_o), 0);
        check({tag, "_round_idx"}, int'(bus.round_idx_o), 0);
        check({tag, "_rate_sel"}, int'(bus.rate_sel_o), 0);
    endtask

    // One hash job; with rst_mid set, reset is asserted during SQUEEZE at idx 10.
    task automatic run_job(input logic [1:0] m, input int ob, input int nb, input int gap,
                           input bit rst_mid);
        int nout, t, g;
        bit acc;
        nout = (m >= 2 || ob == 0) ? 1 : ob;
        @(posedge clk);
        #1;
        bus.start_i = 1'b1;
        bus.mode_i = m;
        bus.out_blocks_i = CW'(ob);
        job_mode = m;
        for (int k = 0; k < nout; k++) exp_q.push_back('{last: (k == nout - 1), rounds: NR * (nb + k)});
        @(negedge clk);
        check("state_clr_pulse", int'(bus.state_clr_o), 1);
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        bus.mode_i = 2'($urandom);
        bus.out_blocks_i = CW'($urandom);
        for (int b = 0; b < nb; b++) begin
            if (b > 0 && gap > 0) begin
                g = $urandom_range(0, gap);
                bus.in_valid_i = 1'b0;
                repeat (g) begin @(posedge clk); #1; end
            end
            bus.in_valid_i = 1'b1;
            bus.in_last_i = (b == nb - 1);
            acc = 0;
            t = 0;
            while (!acc && t < 200) begin
                @(negedge clk);
                acc = bus.in_ready_o;
                @(posedge clk);
                #1;
                bus.start_i = ($urandom_range(0, 3) == 0);
                t++;
            end
            bus.start_i = 1'b0;
            check("block_accepted", int'(acc), 1);
        end
        // Keep offering junk: it must be ignored once the last block is in.
        bus.in_last_i = 1'($urandom);
        if (rst_mid) begin
            t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (!(bus.round_en_o && bus.round_idx_o == IW'(10) && rounds_cnt > NR + 2)
                       && t < 3000);
            check("reached_squeeze_idx10", int'(t < 3000), 1);
            #2;
            rst = 1'b1;
            #1;
            check_all_zero("mid_reset");
            exp_q.delete();
            bus.in_valid_i = 1'b0;
            repeat (2) @(negedge clk);
            rst = 1'b0;
        end else begin
            t = 0;
            while (bus.busy_o && t < 3000) begin
                @(negedge clk);
                t++;
            end
            bus.in_valid_i = 1'b0;
            bus.in_last_i = 1'b0;
            check("job_busy_low", int'(bus.busy_o), 0);
            check("job_outputs_left", exp_q.size(), 0);
            check("job_round_cycles", rounds_cnt, NR * (nb + nout - 1));
            check("job_absorbs", absorb_cnt, nb);
        end
    endtask

    // Two rounds per cycle, three blocks offered back to back.
    task automatic r2_test();
        int c, nacc, nround, nready;
        int ab[$];
        bit seen_dump;
        @(posedge clk);
        #1;
        bus2.start_i = 1'b1;
        bus2.mode_i = 2'd0;
        bus2.out_blocks_i = CW'(1);
        @(posedge clk);
        #1;
        bus2.start_i = 1'b0;
        bus2.in_valid_i = 1'b1;
        bus2.in_last_i = 1'b0;
        c = 0; nacc = 0; nround = 0; nready = 0; seen_dump = 0;
        while (!seen_dump && c < 100) begin
            @(negedge clk);
            if (bus2.out_valid_o) begin
                seen_dump = 1;
            end else begin
                if (bus2.absorb_en_o) begin
                    ab.push_back(c);
                    nacc++;
                end
                if (bus2.in_ready_o && bus2.round_en_o) begin
                    nready++;
                    check("r2_ready_idx", int'(bus2.round_idx_o), 22);
                end
                if (bus2.round_en_o) nround++;
                @(posedge clk);
                #1;
                bus2.in_last_i = (nacc == 2);
                c++;
            end
        end
        check("r2_dump_reached", int'(seen_dump), 1);
        check("r2_round_cycles", nround, 36);
        check("r2_ready_in_permute", nready, 2);
        check("r2_absorbs", ab.size(), 3);
        for (int i = 0; i < ab.size() && i < 3; i++) check("r2_absorb_cycle", ab[i], 12 * i);
        check("r2_out_last", int'(bus2.out_last_o), 1);
        bus2.in_valid_i = 1'b0;
        @(posedge clk);
        #1;
        bus2.out_ready_i = 1'b1;
        @(posedge clk);
        #1;
        bus2.out_ready_i = 1'b0;
        @(negedge clk);
        check("r2_busy_low", int'(bus2.busy_o), 0);
    endtask

    initial begin
        rst = 1'b1;
        bus.start_i = 1'b1;
        bus.mode_i = 2'd3;
        bus.out_blocks_i = CW'(5);
        bus.in_valid_i = 1'b0;
        bus.in_last_i = 1'b0;
        bus2.start_i = 1'b0;
        bus2.mode_i = 2'd0;
        bus2.out_blocks_i = '0;
        bus2.in_valid_i = 1'b0;
        bus2.in_last_i = 1'b0;
        bus2.out_ready_i = 1'b0;
        #1;
        check_all_zero("reset");
        repeat (3) @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        stall_left = 5;
        run_job(2'd0, 3, 1, 0, 1'b0);
        run_job(2'd2, 7, 2, 0, 1'b0);
        run_job(2'd1, 0, 3, 30, 1'b0);
        run_job(2'd0, 3, 1, 0, 1'b1);
        run_job(2'd0, 3, 1, 0, 1'b0);
        for (int j = 0; j < 8; j++) begin
            if ($urandom_range(0, 1) == 1) stall_left = $urandom_range(1, 6);
            run_job(2'($urandom), $urandom_range(0, 4), $urandom_range(1, 4), 30, 1'b0);
        end
        r2_test();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sponge_ctrl.md
SPONGE_CTRL -- requirements
Module: sponge_ctrl

Interface
REQ-001 SHALL have parameter NUM_ROUNDS, default 24, permutation rounds per block.
REQ-002 SHALL have parameter ROUNDS_PER_CYCLE, default 1, rounds executed per round_en_o cycle.
REQ-003 SHALL have parameter CNT_W, default 16, width of squeeze block count.
REQ-004 SHALL have port clk  in  1  clock, rising edge.
REQ-005 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have port start_i  in  1  begin new hash; samples mode_i, out_blocks_i.
REQ-007 SHALL have port mode_i  in  2  0 SHAKE128, 1 SHAKE256, 2 SHA3-256, 3 SHA3-512.
REQ-008 SHALL have port out_blocks_i  in  CNT_W  squeeze blocks requested (XOF modes).
REQ-009 SHALL have port in_valid_i  in  1  padded rate block available.
REQ-010 SHALL have port in_last_i  in  1  offered block is final; qualified by in_valid_i.
REQ-011 SHALL have port in_ready_o  out  1  block accepted when in_valid_i and in_ready_o are both high.
REQ-012 SHALL have port absorb_en_o  out  1  datapath XORs block into state this edge.
REQ-013 SHALL have port state_clr_o  out  1  datapath zeroes state this edge.
REQ-014 SHALL have port round_en_o  out  1  datapath applies ROUNDS_PER_CYCLE rounds this edge.
REQ-015 SHALL have port round_idx_o  out  $clog2(NUM_ROUNDS)  index of first round applied this cycle.
REQ-016 SHALL have port rate_sel_o  out  2  latched mode, selects rate width in datapath.
REQ-017 SHALL have port out_valid_o  out  1  rate block of state is a valid output block.
REQ-018 SHALL have port out_last_o  out  1  current output block is final.
REQ-019 SHALL have port out_ready_i  in  1  consumer takes block when out_valid_o and out_ready_i are both high.
REQ-020 SHALL have port busy_o  out  1  high in every state except IDLE.

Function
REQ-021 States SHALL be IDLE, WAIT_ABSORB, PERMUTE, DUMP, SQUEEZE; permutation SHALL take P = NUM_ROUNDS/ROUNDS_PER_CYCLE cycles.
REQ-022 IDLE: start_i SHALL latch mode and remaining count, pulse state_clr_o for 1 cycle, go WAIT_ABSORB; in_ready_o SHALL be 0.
REQ-023 Remaining count SHALL be 1 for modes 2/3 regardless of out_blocks_i; SHALL be 1 when out_blocks_i = 0.
REQ-024 WAIT_ABSORB: in_ready_o = 1; on acceptance absorb_en_o = 1 that cycle, last flag <= in_last_i, round counter <= 0, go PERMUTE.
REQ-025 PERMUTE/SQUEEZE: round_en_o = 1 every cycle; round_idx_o SHALL step 0, R, 2R, ... NUM_ROUNDS-R (R = ROUNDS_PER_CYCLE).
REQ-026 On the final PERMUTE step with last flag clear, in_ready_o SHALL be 1; acceptance SHALL assert absorb_en_o and restart PERMUTE at idx 0 with no bubble; no acceptance -> WAIT_ABSORB.
REQ-027 On the final PERMUTE step with last flag set, in_ready_o SHALL be 0 and next state SHALL be DUMP.
REQ-028 DUMP: out_valid_o = 1, out_last_o = (remaining == 1); round_en_o = 0; state held until out_ready_i.
REQ-029 DUMP handshake: remaining decrements; if out_last_o -> IDLE, else -> SQUEEZE.
REQ-030 SQUEEZE final step SHALL go to DUMP.
REQ-031 start_i outside IDLE, in_valid_i while in_ready_o = 0, and out_ready_i outside DUMP SHALL be ignored.
REQ-032 mode_i and out_blocks_i SHALL be sampled only on start_i in IDLE.
REQ-033 absorb_en_o, state_clr_o and out_valid_o SHALL never be high in the same cycle.

Reset
REQ-034 rst SHALL force IDLE, counters 0, all outputs 0 (rate_sel_o 0, busy_o 0), asynchronously, including mid-permutation.
REQ-035 First start_i after rst release SHALL behave identically to a cold start.

Structure
REQ-036 Package sponge_pkg SHALL hold mode_t, state_t, per-mode rate constants (168, 136, 136, 72 bytes) and NUM_ROUNDS default.
REQ-037 Round counter SHALL be sub-module sponge_round_ctr (clear, enable, idx, last-step flag).
REQ-038 NUM_ROUNDS % ROUNDS_PER_CYCLE != 0 SHALL fail elaboration.

Verification
REQ-039 SHAKE128, R=1, out_blocks 3, one last block -> absorb_en 1 cycle, idx 0..23, 3 DUMP transfers separated by 24-cycle SQUEEZE, out_last on 3rd, busy low after.
REQ-040 R=2, 3 blocks with in_valid_i held high -> absorb_en at cycles 0, 12, 24, in_ready_o only at idx 22, 36 round_en cycles, then DUMP.
REQ-041 out_ready_i low 5 cycles in DUMP -> out_valid_o held, round_en_o 0, remaining unchanged.
REQ-042 SHA3-256 with out_blocks_i 7 -> exactly one output transfer, out_last_o high.
REQ-043 rst at SQUEEZE idx 10 -> outputs 0 immediately, IDLE; next start_i hashes correctly.
REQ-044 out_blocks_i 0 -> one output block; start_i during PERMUTE -> no effect.
